// File: rtl/input_conditioner_if.sv
// Pad-input / conditioned-event bundle between the pad ring and input_conditioner.
// The master drives the raw pads and enable; the slave returns levels and edge strobes.
interface input_conditioner_if #(
  parameter int WIDTH = 8
);
  logic             ena;
  logic [WIDTH-1:0] raw_in;
  logic [WIDTH-1:0] level_out;
  logic [WIDTH-1:0] rise_out;
  logic [WIDTH-1:0] fall_out;
  logic             any_edge;

  modport master (
    output ena,
    output raw_in,
    input  level_out,
    input  rise_out,
    input  fall_out,
    input  any_edge
  );

  modport slave (
    input  ena,
    input  raw_in,
    output level_out,
    output rise_out,
    output fall_out,
    output any_edge
  );
endinterface

// File: rtl/input_conditioner.sv
// Per-bit 2-flop synchronizer plus stability-counter debouncer.
// Emits clean levels and single-cycle rise/fall strobes for the downstream FSM.
module input_conditioner #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input_conditioner_if.slave   cond
);

  localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;

  logic [CNT_W-1:0] cnt     [WIDTH];
  logic [CNT_W-1:0] cnt_nxt [WIDTH];

  logic [WIDTH-1:0] level_q;
  logic [WIDTH-1:0] level_nxt;
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] rise_nxt;
  logic [WIDTH-1:0] fall_q;
  logic [WIDTH-1:0] fall_nxt;
  logic             any_q;

  // Synchronizer keeps running while ena is low so s2 is current on resume.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= cond.raw_in;
      s2 <= s1;
    end
  end

  // A sample that agrees with the accepted level restarts the count: no partial credit.
  always_comb begin
    level_nxt = level_q;
    rise_nxt  = '0;
    fall_nxt  = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cnt_nxt[i] = cnt[i];
      if (cond.ena) begin
        if (s2[i] == level_q[i]) begin
          cnt_nxt[i] = '0;
        end else if (cnt[i] < CNT_MAX) begin
          cnt_nxt[i] = cnt[i] + CNT_W'(1);
        end else begin
          cnt_nxt[i]   = '0;
          level_nxt[i] = s2[i];
          rise_nxt[i]  = s2[i];
          fall_nxt[i]  = ~s2[i];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      any_q   <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
      level_q <= level_nxt;
      rise_q  <= rise_nxt;
      fall_q  <= fall_nxt;
      any_q   <= |(rise_nxt | fall_nxt);
    end
  end

  assign cond.level_out = level_q;
  assign cond.rise_out  = rise_q;
  assign cond.fall_out  = fall_q;
  assign cond.any_edge  = any_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner (WIDTH=8, DEBOUNCE_CYCLES=4): vector table, directed
// corner sequences and randomized traffic against a sample-window reference model.
module tb_input_conditioner;

  localparam int W = 8;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  input_conditioner_if #(.WIDTH(W)) bus ();

  input_conditioner #(
    .WIDTH          (W),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk (clk),
    .rst (rst),
    .cond(bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference: delay line for the synchronizer, and per channel a history of enabled
  // samples (1 = disagreed with the accepted level). Accept once the newest D all disagree.
  logic [W-1:0] m_s1, m_s2, m_level, m_rise, m_fall;
  logic [63:0]  m_hist [W];

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_level = '0; m_rise = '0; m_fall = '0;
    for (int c = 0; c < W; c++) m_hist[c] = '0;
  endtask

  task automatic model_edge(input logic [W-1:0] raw, input logic en);
    logic [W-1:0] seen;
    logic [63:0]  win;
    seen   = m_s2;
    m_rise = '0;
    m_fall = '0;
    if (en) begin
      for (int c = 0; c < W; c++) begin
        m_hist[c] = {m_hist[c][62:0], seen[c] != m_level[c]};
        win = m_hist[c];
        if (&win[D-1:0]) begin
          if (seen[c]) m_rise[c] = 1'b1;
          else         m_fall[c] = 1'b1;
          m_level[c] = seen[c];
          m_hist[c]  = '0;
        end
      end
    end
    m_s2 = m_s1;
    m_s1 = raw;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_level"}, 32'(bus.level_out), 32'h0);
    check({tag, "_rise"},  32'(bus.rise_out),  32'h0);
    check({tag, "_fall"},  32'(bus.fall_out),  32'h0);
    check({tag, "_any"},   32'(bus.any_edge),  32'h0);
  endtask

  // One clock: drive, let the edge happen, advance the model, compare just after the edge.
  task automatic step(input logic [W-1:0] raw, input logic en);
    bus.raw_in = raw;
    bus.ena    = en;
    @(posedge clk);
    model_edge(raw, en);
    #1;
    check("m_level", 32'(bus.level_out), 32'(m_level));
    check("m_rise",  32'(bus.rise_out),  32'(m_rise));
    check("m_fall",  32'(bus.fall_out),  32'(m_fall));
    check("m_any",   32'(bus.any_edge),  32'(|(m_rise | m_fall)));
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  typedef struct {
    logic [W-1:0] raw;
    logic [W-1:0] lvl;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
  } vec_t;

  vec_t tbl [25];

  int           rise_n, rise_row, early;
  logic [W-1:0] rnd_raw;
  logic         rnd_en;

  initial begin
    // clean step on bit 0
    tbl[0]  = '{8'h01, 8'h00, 8'h00, 8'h00};
    tbl[1]  = '{8'h01, 8'h00, 8'h00, 8'h00};
    tbl[2]  = '{8'h01, 8'h00, 8'h00, 8'h00};
    tbl[3]  = '{8'h01, 8'h00, 8'h00, 8'h00};
    tbl[4]  = '{8'h01, 8'h00, 8'h00, 8'h00};
    tbl[5]  = '{8'h01, 8'h01, 8'h01, 8'h00};
    tbl[6]  = '{8'h01, 8'h01, 8'h00, 8'h00};
    // 3-cycle glitch on bit 2: rejected
    tbl[7]  = '{8'h05, 8'h01, 8'h00, 8'h00};
    tbl[8]  = '{8'h05, 8'h01, 8'h00, 8'h00};
    tbl[9]  = '{8'h05, 8'h01, 8'h00, 8'h00};
    tbl[10] = '{8'h01, 8'h01, 8'h00, 8'h00};
    tbl[11] = '{8'h01, 8'h01, 8'h00, 8'h00};
    tbl[12] = '{8'h01, 8'h01, 8'h00, 8'h00};
    tbl[13] = '{8'h01, 8'h01, 8'h00, 8'h00};
    // 4-cycle pulse on bit 2: accepted, then released
    tbl[14] = '{8'h05, 8'h01, 8'h00, 8'h00};
    tbl[15] = '{8'h05, 8'h01, 8'h00, 8'h00};
    tbl[16] = '{8'h05, 8'h01, 8'h00, 8'h00};
    tbl[17] = '{8'h05, 8'h01, 8'h00, 8'h00};
    tbl[18] = '{8'h01, 8'h01, 8'h00, 8'h00};
    tbl[19] = '{8'h01, 8'h05, 8'h04, 8'h00};
    tbl[20] = '{8'h01, 8'h05, 8'h00, 8'h00};
    tbl[21] = '{8'h01, 8'h05, 8'h00, 8'h00};
    tbl[22] = '{8'h01, 8'h05, 8'h00, 8'h00};
    tbl[23] = '{8'h01, 8'h01, 8'h00, 8'h04};
    tbl[24] = '{8'h01, 8'h01, 8'h00, 8'h00};

    // reset held with pads high: nothing may move
    bus.raw_in = 8'hFF;
    bus.ena    = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_zero("rst_hold");
    bus.raw_in = 8'h00;
    #3 rst = 1'b0;

    for (int r = 0; r < 25; r++) begin
      step(tbl[r].raw, 1'b1);
      check("tbl_level", 32'(bus.level_out), 32'(tbl[r].lvl));
      check("tbl_rise",  32'(bus.rise_out),  32'(tbl[r].rise));
      check("tbl_fall",  32'(bus.fall_out),  32'(tbl[r].fall));
      check("tbl_any",   32'(bus.any_edge),  32'(|(tbl[r].rise | tbl[r].fall)));
    end

    // bounce: 1,1,1,0 then steady 1 -> one rise, timed from the last run
    do_reset();
    rise_n = 0; rise_row = -1;
    for (int r = 0; r < 14; r++) begin
      step((r == 3) ? 8'h00 : 8'h01, 1'b1);
      if (bus.rise_out[0]) begin rise_n++; rise_row = r; end
    end
    check("bounce_count", 32'(rise_n), 32'd1);
    check("bounce_row",   32'(rise_row), 32'd9);

    // ena freeze on bit 5 after two counted samples
    do_reset();
    early = 0;
    for (int r = 0; r < 16; r++) begin
      step(8'h20, !(r >= 4 && r < 14));
      if (r < 15 && bus.rise_out != 8'h00) early++;
    end
    check("freeze_early", 32'(early), 32'd0);
    check("freeze_rise",  32'(bus.rise_out), 32'h20);
    step(8'h20, 1'b1);
    check("freeze_after", 32'(bus.rise_out), 32'h00);

    // multi-channel: joint rise, single fall, then opposite directions in one cycle
    do_reset();
    for (int r = 0; r < 7; r++) begin
      step(8'h81, 1'b1);
      if (r == 5) check("mc_rise", 32'(bus.rise_out), 32'h81);
    end
    for (int r = 0; r < 7; r++) begin
      step(8'h80, 1'b1);
      if (r == 5) check("mc_fall0", 32'(bus.fall_out), 32'h01);
    end
    for (int r = 0; r < 7; r++) begin
      step(8'h01, 1'b1);
      if (r == 5) begin
        check("mc_x_rise", 32'(bus.rise_out), 32'h01);
        check("mc_x_fall", 32'(bus.fall_out), 32'h80);
      end
    end

    // mid-count asynchronous reset, visible before the next clock edge
    for (int r = 0; r < 4; r++) step(8'hFF, 1'b1);
    check("pre_rst_level", 32'(bus.level_out), 32'h01);
    #2 rst = 1'b1;
    #1 check_zero("async_rst");
    model_reset();
    @(posedge clk);
    #1 check_zero("rst_edge");
    #3 rst = 1'b0;
    for (int r = 0; r < 6; r++) begin
      step(8'hFF, 1'b1);
      if (r == 4) check("post_rst_e5", 32'(bus.level_out), 32'h00);
    end
    check("post_rst_level", 32'(bus.level_out), 32'hFF);
    check("post_rst_rise",  32'(bus.rise_out),  32'hFF);

    // randomized traffic: occasional multi-bit flips, ena mostly high
    rnd_raw = 8'hFF;
    for (int r = 0; r < 600; r++) begin
      if ($urandom_range(0, 5) == 0) rnd_raw = rnd_raw ^ 8'($urandom);
      rnd_en = ($urandom_range(0, 7) != 0);
      step(rnd_raw, rnd_en);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Per-bit input conditioning stage that sits directly upstream of the FSM core in the tt_um_luis top.
- Takes raw asynchronous pad inputs (ui_in) and synchronizes each bit with a 2-flop chain.
- Debounces each bit with a per-bit stability counter.
- Produces clean levels plus single-cycle rise/fall strobes that the FSM consumes as its event inputs.

Parameters:
- WIDTH, 8, number of independent input channels.
- DEBOUNCE_CYCLES, 16, consecutive synchronized samples a new value must hold before being accepted; legal range 2..65535.
- CNT_W, $clog2(DEBOUNCE_CYCLES), width of each per-bit counter; derived, not overridden.

Ports:
- clk  input  1  single system clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- ena  input  1  design enable; when low, debounce progress is frozen.
- raw_in  input  WIDTH  unsynchronized pad inputs.
- level_out  output  WIDTH  debounced, registered level per bit.
- rise_out  output  WIDTH  1-cycle strobe when level_out bit goes 0->1.
- fall_out  output  WIDTH  1-cycle strobe when level_out bit goes 1->0.
- any_edge  output  1  OR of rise_out|fall_out, registered with them (same cycle).

Behaviour:
- Reset (rst=1, asynchronous assert, synchronous-to-clk effect on release):
  - Both sync flops, all counters, level_out, rise_out, fall_out and any_edge go to 0 immediately.
- Synchronizer:
  - s1 <= raw_in; s2 <= s1.
  - Always runs, regardless of ena.
  - Only s2 feeds the debounce logic.
- Per-bit debounce, evaluated each rising edge when ena=1:
  - s2[i] == level_out[i]: cnt[i] <= 0.
  - s2[i] != level_out[i] and cnt[i] < DEBOUNCE_CYCLES-1: cnt[i] <= cnt[i]+1.
  - s2[i] != level_out[i] and cnt[i] == DEBOUNCE_CYCLES-1: level_out[i] <= s2[i]; cnt[i] <= 0; rise_out[i] or fall_out[i] <= 1 per direction.
- Strobes:
  - rise_out, fall_out and any_edge are high for exactly one cycle, the same cycle level_out shows the new value.
  - They are 0 in every other cycle.
- Latency:
  - Let edge E0 be the first rising edge at which raw_in[i] is stably at the new value, with the value held continuously.
  - level_out[i] and the strobe update at edge E(DEBOUNCE_CYCLES+1), i.e. DEBOUNCE_CYCLES+2 rising edges counting E0.
- Glitch rejection:
  - Any pulse shorter than DEBOUNCE_CYCLES synchronized cycles returns s2 to level_out, which clears cnt.
  - No strobe is produced and level_out does not change.
- Bounce: each return to the accepted level restarts the count from 0. There is no partial credit.
- ena=0:
  - cnt and level_out hold their values; rise_out, fall_out and any_edge are forced to 0.
  - Counting resumes from the held cnt when ena returns to 1.
- Channels are fully independent; several bits may strobe in the same cycle.
- A counter never exceeds DEBOUNCE_CYCLES-1; there is no wrap.
- Mid-operation reset:
  - Discards all in-progress counts.
  - After release, a raw input already held at 1 requires the full latency and then produces a rise strobe.

Test Plan (DEBOUNCE_CYCLES=4, WIDTH=8):
- Reset check: assert rst asynchronously mid-cycle -> all outputs 0 before the next clk edge; hold raw_in=0xFF during reset -> no change while rst=1.
- Clean step: raw_in 0x00->0x01 stable before edge E0 -> level_out=0x01 and rise_out=0x01, any_edge=1 for one cycle at edge E5, then rise_out=0x00.
- Glitch: raw_in[2] high for 3 cycles then low -> level_out stays 0x00, no strobes. Repeat with a 4-cycle pulse -> rise_out[2] strobe, then fall_out[2] strobe later.
- Bounce: raw_in[0] pattern 1,1,1,0,1,1,1,1 -> single rise_out[0], timed from the final 1-run start (count restarted).
- ena freeze: start a 0->1 on bit 5, drop ena after 2 counted cycles for 10 cycles, then raise it -> no strobe while ena=0; rise_out=0x20 two edges after ena returns.
- Multi-channel / reset mid-count: raw_in 0x00->0x81 and 0x81->0x80 staggered -> independent rise/fall strobes on bits 7 and 0, including the same cycle when aligned. Then pulse rst with cnt=2 -> cnt cleared; with raw_in held 0xFF, level_out=0xFF exactly 6 edges after release.
